load_store_unit: RTL

- Initiator side of the data-memory port: accepts one load/store request at a time from the MEM stage and drives the word-addressed memory's Address/WriteData/MemoryRead/MemoryWrite.
- Adds byte/halfword loads with sign or zero extension, and byte/halfword stores via read-modify-write.
- Detects misaligned accesses and reports them as errors without touching memory.
- Sits between the pipeline MEM stage and the 256-byte data memory. That memory reads combinationally and writes on negedge Clock.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_byte_lane.sv | 59 +++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared op/state encodings and access helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_SB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic size_e access_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_signed_load(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] offset);
    case (access_size(op))
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - big-endian byte/halfword extract-extend and store merge
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [31:0] word,
  input  logic [31:0] data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Offset 0 is the most significant byte/halfword of the word.
  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[15:0] : word[31:16];
  end

  // Load result: selected lane widened by sign or zero extension.
  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase
  end

  // Store merge: only the addressed lane of the read word is replaced.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    merged[31:24] = data[7:0];
          2'd1:    merged[23:16] = data[7:0];
          2'd2:    merged[15:8]  = data[7:0];
          default: merged[7:0]   = data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged[15:0]  = data[15:0];
        else           merged[31:16] = data[15:0];
      end
      default: merged = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator for the word-addressed data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [2:0]            ReqOp,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqWData,
  output logic                  RespValid,
  output logic [DATA_WIDTH-1:0] RespRData,
  output logic                  RespError,
  output logic [ADDR_WIDTH-3:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemoryRead,
  output logic                  MemoryWrite,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  logic [1:0]            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            offset_q, offset_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-3:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  // The lane only matters in READ, where it sees the live memory word.
  lsu_byte_lane u_lane (
    .offset    (offset_q),
    .size      (access_size(op_q)),
    .sign_ext  (is_signed_load(op_q)),
    .word      (MemReadData),
    .data      (wdata_q),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  // Request sequencing: capture on accept, read, optional merge-write, one-cycle response.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          op_d     = ReqOp;
          offset_d = ReqAddr[1:0];
          wdata_d  = ReqWData;
          if (is_misaligned(ReqOp, ReqAddr[1:0])) begin
            // Memory address/data registers are left alone so the port holds its last values.
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (ReqOp == OP_SW) begin
            state_d     = ST_WRITE;
            err_d       = 1'b0;
            mem_addr_d  = ReqAddr[ADDR_WIDTH-1:2];
            mem_wdata_d = ReqWData;
          end else begin
            state_d    = ST_READ;
            err_d      = 1'b0;
            mem_addr_d = ReqAddr[ADDR_WIDTH-1:2];
          end
        end
      end
      ST_READ: begin
        if (is_store(op_q)) begin
          state_d     = ST_WRITE;
          mem_wdata_d = lane_merged;
        end else begin
          state_d = ST_RESP;
          rdata_d = lane_load;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
        rdata_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      offset_q    <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Write enable is gated by Reset so an interrupted read-modify-write never lands.
  always_comb begin
    ReqReady     = (state_q == ST_IDLE);
    MemoryRead   = (state_q == ST_READ);
    MemoryWrite  = (state_q == ST_WRITE) & ~Reset;
    RespValid    = (state_q == ST_RESP);
    RespError    = (state_q == ST_RESP) & err_q;
    RespRData    = rdata_q;
    MemAddress   = mem_addr_q;
    MemWriteData = mem_wdata_q;
  end

endmodule
